// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IF_BUSY = 2'b01,
        DM_BUSY = 2'b10
    } arb_state_t;

    localparam int MAX_DBURST_DEFAULT = 4;
    localparam int DBURST_W           = 3;

endpackage

// File: rtl/arb_fsm.sv
// Ownership FSM for the shared memory port, plus the data-burst counter
// that guarantees a waiting fetch eventually wins.
import mem_arbiter_pkg::*;

module arb_fsm #(
    parameter int MAX_DBURST = MAX_DBURST_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_req,
    input  logic       dm_rd,
    input  logic       dm_wr,
    input  logic       mem_done,
    output arb_state_t state,
    output logic       issue_if,
    output logic       issue_dm,
    output logic       dm_is_wr
);

    localparam logic [DBURST_W-1:0] BURST_MAX = DBURST_W'(MAX_DBURST);

    arb_state_t          next_state;
    logic                dm_req;
    logic [DBURST_W-1:0] dburst_cnt;

    assign dm_req = dm_rd | dm_wr;

    // Data wins ties until it has taken MAX_DBURST grants in a row over a waiting fetch.
    always_comb begin
        next_state = state;
        issue_if   = 1'b0;
        issue_dm   = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req && (!if_req || dburst_cnt != BURST_MAX)) begin
                    issue_dm   = 1'b1;
                    next_state = DM_BUSY;
                end else if (if_req) begin
                    issue_if   = 1'b1;
                    next_state = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dburst_cnt <= '0;
        end else if (!if_req || issue_if) begin
            dburst_cnt <= '0;
        end else if (issue_dm && dburst_cnt != BURST_MAX) begin
            dburst_cnt <= dburst_cnt + 1'b1;
        end
    end

    // Remember the data op so completion is correct even if the request drops early.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_is_wr <= 1'b0;
        end else if (issue_dm) begin
            dm_is_wr <= dm_wr;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter top: steers the shared memory port and the requester handshakes
// from the ownership state; all outputs are forced low during reset.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int MAX_DBURST = MAX_DBURST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    input  logic        dm_dump,
    output logic [15:0] if_data,
    output logic [15:0] dm_rdata,
    output logic        if_stall,
    output logic        dm_stall,
    output logic        if_done,
    output logic        dm_done,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_dump,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_stall,
    input  logic        mem_done
);

    arb_state_t state;
    logic       issue_if;
    logic       issue_dm;
    logic       dm_is_wr;
    logic       unused_mem_stall;

    assign unused_mem_stall = mem_stall;

    arb_fsm #(
        .MAX_DBURST (MAX_DBURST)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .dm_rd    (dm_rd),
        .dm_wr    (dm_wr),
        .mem_done (mem_done),
        .state    (state),
        .issue_if (issue_if),
        .issue_dm (issue_dm),
        .dm_is_wr (dm_is_wr)
    );

    always_comb begin
        if_data   = '0;
        dm_rdata  = '0;
        if_stall  = 1'b0;
        dm_stall  = 1'b0;
        if_done   = 1'b0;
        dm_done   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_dump  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (issue_dm) begin
                        mem_rd    = dm_rd;
                        mem_wr    = dm_wr;
                        mem_dump  = dm_dump;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                    end else if (issue_if) begin
                        mem_rd   = 1'b1;
                        mem_addr = if_addr;
                    end
                end
                IF_BUSY: begin
                    mem_addr = if_addr;
                    if (mem_done) begin
                        if_done = 1'b1;
                        if_data = mem_rdata;
                    end
                end
                DM_BUSY: begin
                    mem_addr  = dm_addr;
                    mem_wdata = dm_is_wr ? dm_wdata : 16'h0000;
                    if (mem_done) begin
                        dm_done  = 1'b1;
                        dm_rdata = dm_is_wr ? 16'h0000 : mem_rdata;
                    end
                end
                default: ;
            endcase
            if_stall = if_req & ~if_done;
            dm_stall = (dm_rd | dm_wr) & ~dm_done;
        end
    end

endmodule
